uart_tx_scheduler: RTL and testbench

Transmit-side controller for the UART datapath. It arbitrates round-robin between two byte requesters over valid/ready handshakes and latches the UART configuration at frame acceptance. It then sequences the serial frame (start, 5–8 data bits LSB-first, optional parity, 1–2 stop bits) onto the `tx` line at the configured baud rate. It sits between the traffic sources and the physical TX pin; parity, framing and break error injection are applied here.

---
 rtl/uart_tx_scheduler_pkg.sv | 23 ++
 rtl/uart_tx_scheduler_baud_tick_gen.sv | 41 ++++
 rtl/uart_tx_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared UART types and constants.
//   UART_DATA_WIDTH      : width of the byte buses between sources and the TX path
//   baudRateEnum         : supported line rates
//   dataTypeEnum         : 5..8 data bits per frame
//   parityTypeEnum       : even / odd parity
//   stopBitEnum          : one / two stop bits
//   UartTxSchedStateEnum : frame sequencing states of the TX scheduler
//   data_bit_count()     : number of data bits encoded by a dataTypeEnum value
package uart_tx_scheduler_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {BAUD_4800, BAUD_9600, BAUD_19200} baudRateEnum;
  typedef enum logic [1:0] {FIVE_BIT, SIX_BIT, SEVEN_BIT, EIGHT_BIT} dataTypeEnum;
  typedef enum logic {EVEN_PARITY, ODD_PARITY} parityTypeEnum;
  typedef enum logic {ONE_BIT, TWO_BIT} stopBitEnum;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} UartTxSchedStateEnum;

  function automatic logic [3:0] data_bit_count(input dataTypeEnum dt);
    return 4'd5 + {2'b00, dt};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_baud_tick_gen.sv
// Bit-period timer, shared with the RX side.
//   clk, reset : clock and asynchronous active-high reset
//   restart    : load a new period (div) and start timing the first bit
//   div        : bit period in clock cycles, captured on restart
//   enable     : timer runs while high
//   tick       : high on the last cycle of each bit period
module uart_baud_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  input  logic             enable,
  output logic             tick
);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt_reg;

  // Down-counter: reaching zero ends the bit, and the counter reloads from the
  // period captured at restart so every bit of a frame has the same length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= '0;
      cnt_reg <= '0;
    end else if (restart) begin
      div_reg <= div;
      cnt_reg <= div - DIV_W'(1);
    end else if (enable) begin
      if (cnt_reg == '0) begin
        cnt_reg <= div_reg - DIV_W'(1);
      end else begin
        cnt_reg <= cnt_reg - DIV_W'(1);
      end
    end
  end

  assign tick = enable && (cnt_reg == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: round-robin arbitration between two byte sources,
// configuration latch at frame acceptance, and serial frame sequencing with
// parity / framing / break error injection.
//   clk, reset                 : clock, asynchronous active-high reset
//   req0*/req1*                : valid/ready byte requesters (ready is combinational)
//   uartBaudRate..uartStopBits : line configuration, sampled at accept
//   uart*ErrorInjection        : error injection controls, sampled at accept
//   tx                         : registered serial line, idle high
//   busy                       : frame in progress
//   grantId                    : requester of the current or last frame
//   frameDone                  : pulse on the final cycle of the last stop bit
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int CLK_FREQ_HZ = 1843200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0Valid,
  input  logic [DATA_WIDTH-1:0] req0Data,
  output logic                  req0Ready,
  input  logic                  req1Valid,
  input  logic [DATA_WIDTH-1:0] req1Data,
  output logic                  req1Ready,
  input  baudRateEnum           uartBaudRate,
  input  dataTypeEnum           uartDataType,
  input  logic                  uartParityEnable,
  input  parityTypeEnum         uartParityType,
  input  stopBitEnum            uartStopBits,
  input  logic                  uartParityErrorInjection,
  input  logic                  uartFramingErrorInjection,
  input  logic                  uartBreakingErrorInjection,
  output logic                  tx,
  output logic                  busy,
  output logic                  grantId,
  output logic                  frameDone
);

  localparam int DIV_W = $clog2(CLK_FREQ_HZ / 4800 + 1);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_4800  = DIV_W'(CLK_FREQ_HZ / 4800);
  localparam logic [DIV_W-1:0] DIV_9600  = DIV_W'(CLK_FREQ_HZ / 9600);
  localparam logic [DIV_W-1:0] DIV_19200 = DIV_W'(CLK_FREQ_HZ / 19200);

  UartTxSchedStateEnum state_reg, state_next;
  logic                  tx_reg, tx_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                  stop_cnt_reg, stop_cnt_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [CNT_W-1:0]      last_bit_reg;
  logic                  parity_en_reg;
  logic                  parity_bit_reg;
  logic                  two_stop_reg;
  logic                  framing_inj_reg;
  logic                  break_inj_reg;
  logic                  last_grant_reg;
  logic                  grant_id_reg;

  logic                  arb_open;
  logic                  grant_sel;
  logic                  accept;
  logic                  load;
  logic                  tick;
  logic                  frame_done;
  logic [DIV_W-1:0]      div_sel;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] used_mask;
  logic [3:0]            new_bits;
  logic                  new_parity;
  logic [CNT_W-1:0]      bit_cnt_inc;

  // ---------------- arbitration ----------------
  // Readies are gated by reset as well so they drop the instant reset rises.
  assign arb_open  = (state_reg == IDLE) && !reset;
  assign grant_sel = (req0Valid && req1Valid) ? ~last_grant_reg : req1Valid;
  assign req0Ready = arb_open && !grant_sel && req0Valid;
  assign req1Ready = arb_open &&  grant_sel && req1Valid;
  assign accept    = arb_open && (req0Valid || req1Valid);
  assign sel_data  = grant_sel ? req1Data : req0Data;

  always_comb begin
    div_sel = DIV_19200;
    case (uartBaudRate)
      BAUD_4800:  div_sel = DIV_4800;
      BAUD_9600:  div_sel = DIV_9600;
      BAUD_19200: div_sel = DIV_19200;
      default:    div_sel = DIV_19200;
    endcase
  end

  // ---------------- parity of the bits actually sent ----------------
  assign new_bits = data_bit_count(uartDataType);

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
      assign used_mask[gi] = (32'(gi) < 32'(new_bits));
    end
  endgenerate

  assign new_parity = (^(sel_data & used_mask))
                    ^ (uartParityType == ODD_PARITY)
                    ^ uartParityErrorInjection;

  // ---------------- bit timer ----------------
  uart_baud_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (load),
    .div     (div_sel),
    .enable  (state_reg != IDLE),
    .tick    (tick)
  );

  // ---------------- frame sequencing ----------------
  assign bit_cnt_inc = bit_cnt_reg + CNT_W'(1);

  always_comb begin
    state_next    = state_reg;
    tx_next       = tx_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    frame_done    = 1'b0;
    load          = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          state_next    = START;
          tx_next       = 1'b0;
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          load          = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          tx_next    = data_reg[bit_cnt_reg];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_reg == last_bit_reg) begin
            if (parity_en_reg) begin
              state_next = PARITY;
              tx_next    = parity_bit_reg;
            end else begin
              state_next = STOP;
              tx_next    = ~framing_inj_reg;
            end
          end else begin
            bit_cnt_next = bit_cnt_inc;
            tx_next      = data_reg[bit_cnt_inc];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          tx_next    = ~framing_inj_reg;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt_reg == two_stop_reg) begin
            state_next = IDLE;
            tx_next    = 1'b1;
            frame_done = 1'b1;
          end else begin
            stop_cnt_next = 1'b1;
            // Framing injection only corrupts the first stop bit.
            tx_next       = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
    // Break holds the line low for every bit; the start bit is already low,
    // so the flag only needs to apply once the frame's config is latched.
    if (break_inj_reg && (state_reg != IDLE) && (state_next != IDLE)) begin
      tx_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      tx_reg          <= 1'b1;
      bit_cnt_reg     <= '0;
      stop_cnt_reg    <= 1'b0;
      data_reg        <= '0;
      last_bit_reg    <= '0;
      parity_en_reg   <= 1'b0;
      parity_bit_reg  <= 1'b0;
      two_stop_reg    <= 1'b0;
      framing_inj_reg <= 1'b0;
      break_inj_reg   <= 1'b0;
      last_grant_reg  <= 1'b1;
      grant_id_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_reg       <= tx_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      if (accept) begin
        data_reg        <= sel_data;
        last_bit_reg    <= CNT_W'(new_bits - 4'd1);
        parity_en_reg   <= uartParityEnable;
        parity_bit_reg  <= new_parity;
        two_stop_reg    <= (uartStopBits == TWO_BIT);
        framing_inj_reg <= uartFramingErrorInjection;
        break_inj_reg   <= uartBreakingErrorInjection;
        last_grant_reg  <= grant_sel;
        grant_id_reg    <= grant_sel;
      end
    end
  end

  assign tx        = tx_reg;
  assign busy      = (state_reg != IDLE);
  assign grantId   = grant_id_reg;
  assign frameDone = frame_done;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
  import uart_tx_scheduler_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0Valid = 1'b0, req1Valid = 1'b0;
  logic [7:0]    req0Data = '0, req1Data = '0;
  logic          req0Ready, req1Ready;
  baudRateEnum   uartBaudRate = BAUD_19200;
  dataTypeEnum   uartDataType = EIGHT_BIT;
  logic          uartParityEnable = 1'b0;
  parityTypeEnum uartParityType = EVEN_PARITY;
  stopBitEnum    uartStopBits = ONE_BIT;
  logic          uartParityErrorInjection = 1'b0;
  logic          uartFramingErrorInjection = 1'b0;
  logic          uartBreakingErrorInjection = 1'b0;
  logic          tx, busy, grantId, frameDone;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .DATA_WIDTH  (8),
    .CLK_FREQ_HZ (192000)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .req0Valid                  (req0Valid),
    .req0Data                   (req0Data),
    .req0Ready                  (req0Ready),
    .req1Valid                  (req1Valid),
    .req1Data                   (req1Data),
    .req1Ready                  (req1Ready),
    .uartBaudRate               (uartBaudRate),
    .uartDataType               (uartDataType),
    .uartParityEnable           (uartParityEnable),
    .uartParityType             (uartParityType),
    .uartStopBits               (uartStopBits),
    .uartParityErrorInjection   (uartParityErrorInjection),
    .uartFramingErrorInjection  (uartFramingErrorInjection),
    .uartBreakingErrorInjection (uartBreakingErrorInjection),
    .tx                         (tx),
    .busy                       (busy),
    .grantId                    (grantId),
    .frameDone                  (frameDone)
  );

  int checks = 0;
  int errors = 0;
  int print_budget = 40;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (print_budget > 0) begin
        print_budget--;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- frame-level reference model ----------------
  bit m_txq[$];
  bit m_last = 1'b1;
  bit m_gid  = 1'b0;
  int accq[$];

  function automatic int div_of(input baudRateEnum b);
    case (b)
      BAUD_4800: return 192000 / 4800;
      BAUD_9600: return 192000 / 9600;
      default:   return 192000 / 19200;
    endcase
  endfunction

  // Expected per-cycle tx of a whole frame, from the line rules.
  task automatic build_frame(input logic [7:0] d);
    bit fr[$];
    bit p;
    int nb;
    int dv;
    nb = 5 + int'(uartDataType);
    dv = div_of(uartBaudRate);
    fr.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      fr.push_back(d[i]);
      p = p ^ d[i];
    end
    if (uartParityEnable) begin
      if (uartParityType == ODD_PARITY) p = ~p;
      if (uartParityErrorInjection) p = ~p;
      fr.push_back(p);
    end
    fr.push_back(uartFramingErrorInjection ? 1'b0 : 1'b1);
    if (uartStopBits == TWO_BIT) fr.push_back(1'b1);
    foreach (fr[k]) begin
      for (int c = 0; c < dv; c++) begin
        m_txq.push_back(uartBreakingErrorInjection ? 1'b0 : fr[k]);
      end
    end
  endtask

  initial begin
    forever begin
      bit e_tx, e_busy, e_fd, e_r0, e_r1, g;
      @(negedge clk);
      if (reset) begin
        m_txq.delete();
        m_last = 1'b1;
        m_gid  = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", frameDone, 0);
        check("rst_rdy0", req0Ready, 0);
        check("rst_rdy1", req1Ready, 0);
        check("rst_gid", grantId, 0);
      end else begin
        g = 1'b0;
        if (m_txq.size() > 0) begin
          e_tx = m_txq[0];
          e_busy = 1'b1;
          e_fd = (m_txq.size() == 1);
          e_r0 = 1'b0;
          e_r1 = 1'b0;
        end else begin
          e_tx = 1'b1;
          e_busy = 1'b0;
          e_fd = 1'b0;
          g = (req0Valid && req1Valid) ? ~m_last : req1Valid;
          e_r0 = req0Valid && !g;
          e_r1 = req1Valid && g;
        end
        check("tx", tx, e_tx);
        check("busy", busy, e_busy);
        check("frameDone", frameDone, e_fd);
        check("req0Ready", req0Ready, e_r0);
        check("req1Ready", req1Ready, e_r1);
        check("grantId", grantId, m_gid);
        if (req0Ready === 1'b1 && req0Valid) accq.push_back(0);
        if (req1Ready === 1'b1 && req1Valid) accq.push_back(1);
        if (m_txq.size() > 0) begin
          void'(m_txq.pop_front());
        end else if (req0Valid || req1Valid) begin
          build_frame(g ? req1Data : req0Data);
          m_last = g;
          m_gid  = g;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit src);
    if (src) req1Valid = 1'b1;
    else     req0Valid = 1'b1;
    step();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
  endtask

  // Samples tx mid-bit and returns the frame length up to frameDone.
  task automatic run_frame(input int dv, output logic [15:0] bits, output int len);
    bits = '1;
    len = -1;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (((c - 1) % dv == dv / 2) && ((c - 1) / dv < 16)) bits[(c - 1) / dv] = tx;
      if (frameDone === 1'b1) begin
        len = c;
        break;
      end
    end
    if (len < 0) fail_bound("frame_timeout");
  endtask

  task automatic wait_idle(input int limit);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) fail_bound("wait_idle");
  endtask

  task automatic print_frame(input string name, input logic [15:0] bits, input int len);
    $display("frame %s: bits=%h len=%0d", name, bits, len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int len;

    // Reset state, with a requester already asking.
    req0Valid = 1'b1;
    step();
    step();
    check("lit_rst_rdy0", req0Ready, 0);
    check("lit_rst_tx", tx, 1);
    check("lit_rst_busy", busy, 0);
    req0Valid = 1'b0;
    uartDataType = FIVE_BIT;
    reset = 1'b0;
    step();

    // Round-robin with both requesters continuously valid.
    req0Data = 8'h15;
    req1Data = 8'h0A;
    accq.delete();
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        step();
        if (accq.size() >= 4) begin
          got = 1'b1;
          break;
        end
      end
      req0Valid = 1'b0;
      req1Valid = 1'b0;
      if (!got) fail_bound("rr_grants");
    end
    wait_idle(200);
    if (accq.size() >= 4) begin
      check("lit_rr_g0", accq[0], 0);
      check("lit_rr_g1", accq[1], 1);
      check("lit_rr_g2", accq[2], 0);
      check("lit_rr_g3", accq[3], 1);
      $display("round-robin grants: %0d %0d %0d %0d", accq[0], accq[1], accq[2], accq[3]);
    end
    step();

    // Single frame: A5, 8 bits, even parity, one stop.
    uartDataType = EIGHT_BIT;
    uartParityEnable = 1'b1;
    uartParityType = EVEN_PARITY;
    uartStopBits = ONE_BIT;
    req0Data = 8'hA5;
    step();
    start_frame(0);
    run_frame(10, bits, len);
    print_frame("single", bits, len);
    check("lit_single_bits", bits[10:0], 11'b10101001010);
    check("lit_single_len", len, 110);
    step();

    // Parity error injection.
    uartParityErrorInjection = 1'b1;
    start_frame(0);
    run_frame(10, bits, len);
    print_frame("parity_inj", bits, len);
    check("lit_parinj_bits", bits[10:0], 11'b11101001010);
    uartParityErrorInjection = 1'b0;
    step();

    // Framing error injection.
    uartFramingErrorInjection = 1'b1;
    start_frame(0);
    run_frame(10, bits, len);
    print_frame("framing_inj", bits, len);
    check("lit_frminj_bits", bits[10:0], 11'b00101001010);
    uartFramingErrorInjection = 1'b0;
    step();

    // Break injection.
    uartBreakingErrorInjection = 1'b1;
    start_frame(0);
    run_frame(10, bits, len);
    print_frame("break_inj", bits, len);
    check("lit_brk_bits", bits[10:0], 11'b0);
    check("lit_brk_len", len, 110);
    uartBreakingErrorInjection = 1'b0;
    step();

    // Short frame from requester 1: 5 bits of FF, odd parity, two stops.
    uartDataType = FIVE_BIT;
    uartParityType = ODD_PARITY;
    uartStopBits = TWO_BIT;
    req1Data = 8'hFF;
    start_frame(1);
    run_frame(10, bits, len);
    print_frame("short", bits, len);
    check("lit_short_bits", bits[8:0], 9'b110111110);
    check("lit_short_len", len, 90);
    step();

    // Mid-frame baud change only affects the next frame.
    uartDataType = EIGHT_BIT;
    uartParityEnable = 1'b0;
    uartStopBits = ONE_BIT;
    req0Data = 8'h3C;
    start_frame(0);
    fork
      run_frame(10, bits, len);
      begin
        repeat (30) @(posedge clk);
        #1 uartBaudRate = BAUD_4800;
      end
    join
    print_frame("cfg_old", bits, len);
    check("lit_cfg_bits0", bits[9:0], 10'b1001111000);
    check("lit_cfg_len0", len, 100);
    step();
    start_frame(0);
    run_frame(40, bits, len);
    print_frame("cfg_new", bits, len);
    check("lit_cfg_bits1", bits[9:0], 10'b1001111000);
    check("lit_cfg_len1", len, 400);
    uartBaudRate = BAUD_19200;
    step();

    // Reset during data bit 3, then requester 0 must win after release.
    uartParityEnable = 1'b1;
    uartParityType = EVEN_PARITY;
    req0Data = 8'hA5;
    start_frame(1);
    repeat (44) step();
    #2;
    reset = 1'b1;
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    #1;
    check("lit_mrst_tx", tx, 1);
    check("lit_mrst_busy", busy, 0);
    check("lit_mrst_done", frameDone, 0);
    check("lit_mrst_rdy0", req0Ready, 0);
    check("lit_mrst_rdy1", req1Ready, 0);
    accq.delete();
    step();
    step();
    reset = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
        step();
        if (accq.size() >= 1) begin
          got = 1'b1;
          break;
        end
      end
      req0Valid = 1'b0;
      req1Valid = 1'b0;
      if (!got) fail_bound("post_reset_grant");
    end
    if (accq.size() >= 1) begin
      check("lit_post_rst_grant", accq[0], 0);
      $display("post-reset grant: %0d", accq[0]);
    end
    wait_idle(300);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
